// File: rtl/nios_sys_oci_dct_pkg.sv
// Shared constants, state encoding and atom codes for the Nios II OCI DCT packer.
package nios_sys_oci_dct_pkg;

  localparam int ATOM_W = 2;
  localparam int DEPTH  = 15;
  localparam int BUF_W  = ATOM_W * DEPTH;
  localparam int CNT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } dct_state_e;

  // 2'b00 is a real atom, not an idle marker; validity comes from atom_valid.
  localparam logic [ATOM_W-1:0] NOP       = 2'b00;
  localparam logic [ATOM_W-1:0] TAKEN     = 2'b01;
  localparam logic [ATOM_W-1:0] NOT_TAKEN = 2'b10;
  localparam logic [ATOM_W-1:0] SYNC      = 2'b11;

  function automatic logic [BUF_W-1:0] push_atom(input logic [BUF_W-1:0] cur,
                                                 input logic [ATOM_W-1:0] atom);
    return {cur[BUF_W-ATOM_W-1:0], atom};
  endfunction

endpackage

// File: rtl/nios_sys_oci_dct_frame_reg.sv
// Output holding register for DCT frames with valid/ready handshake and "free" term.
module nios_sys_oci_dct_frame_reg
  import nios_sys_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [BUF_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_count,
  input  logic             out_ready,
  output logic             frame_valid,
  output logic [BUF_W-1:0] frame_data,
  output logic [CNT_W-1:0] frame_count,
  output logic             free
);

  logic             valid_reg;
  logic [BUF_W-1:0] data_reg;
  logic [CNT_W-1:0] count_reg;

  // A frame being consumed this cycle makes room for the next one in the same edge.
  assign free = !valid_reg || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      count_reg <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      count_reg <= load_count;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign frame_valid = valid_reg;
  assign frame_data  = data_reg;
  assign frame_count = count_reg;

endmodule

// File: rtl/nios_sys_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit frames for the OCI trace FIFO.
// Optional NIOS_OCI_DCT_DROP_COUNT_EN adds a saturating drop_count output.
module nios_sys_nios2_qsys_0_oci_dct_packer
  import nios_sys_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trace_enable,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom,
  input  logic              flush,
  input  logic              clear_overflow,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              frame_valid,
  output logic [BUF_W-1:0]  frame_data,
  output logic [CNT_W-1:0]  frame_count,
  output logic              overflow
`ifdef NIOS_OCI_DCT_DROP_COUNT_EN
  ,
  output logic [7:0]        drop_count
`endif
);

  dct_state_e       state_reg, state_next;
  logic [BUF_W-1:0] dct_buffer_reg, dct_buffer_next;
  logic [CNT_W-1:0] dct_count_reg, dct_count_next;
  logic             flush_pend_reg, flush_pend_next;
  logic             overflow_reg;

  logic             accept;
  logic             drop;
  logic             flush_req;
  logic             emit;
  logic             frame_free;
  logic [BUF_W-1:0] buf_acc;
  logic [CNT_W-1:0] cnt_acc;

  always_comb begin
    accept    = atom_valid && trace_enable && (state_reg != STALL);
    drop      = atom_valid && trace_enable && (state_reg == STALL);
    buf_acc   = accept ? push_atom(dct_buffer_reg, atom) : dct_buffer_reg;
    cnt_acc   = dct_count_reg + {{(CNT_W-1){1'b0}}, accept};
    flush_req = flush || flush_pend_reg;
    // In STALL the count is already full, so the same term releases a stalled frame.
    emit      = frame_free && ((cnt_acc == CNT_FULL) || (flush_req && (cnt_acc != '0)));
  end

  always_comb begin
    state_next      = state_reg;
    dct_buffer_next = buf_acc;
    dct_count_next  = cnt_acc;
    flush_pend_next = 1'b0;
    if (emit) begin
      state_next      = IDLE;
      dct_buffer_next = '0;
      dct_count_next  = '0;
    end else begin
      flush_pend_next = flush_req && (cnt_acc != '0);
      if (cnt_acc == CNT_FULL)
        state_next = STALL;
      else if (cnt_acc != '0)
        state_next = FILL;
      else
        state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      dct_buffer_reg <= '0;
      dct_count_reg  <= '0;
      flush_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dct_buffer_reg <= dct_buffer_next;
      dct_count_reg  <= dct_count_next;
      flush_pend_reg <= flush_pend_next;
    end
  end

  // A drop in the same cycle as a clear must still leave evidence behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      overflow_reg <= 1'b0;
    else if (drop)
      overflow_reg <= 1'b1;
    else if (clear_overflow)
      overflow_reg <= 1'b0;
  end

`ifdef NIOS_OCI_DCT_DROP_COUNT_EN
  logic [7:0] drop_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_count_reg <= '0;
    else if (clear_overflow)
      drop_count_reg <= drop ? 8'd1 : 8'd0;
    else if (drop && (drop_count_reg != 8'hFF))
      drop_count_reg <= drop_count_reg + 8'd1;
  end

  assign drop_count = drop_count_reg;
`endif

  nios_sys_oci_dct_frame_reg u_frame_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (emit),
    .load_data   (buf_acc),
    .load_count  (cnt_acc),
    .out_ready   (out_ready),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_count (frame_count),
    .free        (frame_free)
  );

  assign dct_buffer = dct_buffer_reg;
  assign dct_count  = dct_count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_nios_sys_nios2_qsys_0_oci_dct_packer.sv
// Scoreboard bench for the OCI DCT packer: expected frames queued at stimulus, checked at handshake.
module tb_nios_sys_nios2_qsys_0_oci_dct_packer;
  import nios_sys_oci_dct_pkg::*;

  logic              clk;
  logic              reset_n;
  logic              trace_enable;
  logic              atom_valid;
  logic [ATOM_W-1:0] atom;
  logic              flush;
  logic              clear_overflow;
  logic              out_ready;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              frame_valid;
  logic [BUF_W-1:0]  frame_data;
  logic [CNT_W-1:0]  frame_count;
  logic              overflow;
`ifdef NIOS_OCI_DCT_DROP_COUNT_EN
  logic [7:0]        drop_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];

  nios_sys_nios2_qsys_0_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trace_enable   (trace_enable),
    .atom_valid     (atom_valid),
    .atom           (atom),
    .flush          (flush),
    .clear_overflow (clear_overflow),
    .out_ready      (out_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .frame_count    (frame_count),
    .overflow       (overflow)
`ifdef NIOS_OCI_DCT_DROP_COUNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [CNT_W-1:0] cnt, input logic [BUF_W-1:0] data);
    exp_q.push_back({cnt, data});
  endtask

  // Handshake monitor: sampled on the falling edge, ahead of the edge that consumes the frame.
  always @(negedge clk) begin
    logic [33:0] e;
    if (reset_n && frame_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("frame: data=0x%08h count=%0d", frame_data, frame_count);
        check("frame_data", 32'(frame_data), 32'(e[29:0]));
        check("frame_count", 32'(frame_count), 32'(e[33:30]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    trace_enable = 1'b1;
    atom_valid = 1'b0;
    atom = NOP;
    flush = 1'b0;
    clear_overflow = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_dct_count", 32'(dct_count), 32'd0);
    check("rst_dct_buffer", 32'(dct_buffer), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    tick();

    // 15 TAKEN atoms back-to-back: frame appears one cycle after the 15th.
    push_exp(4'd15, 30'h15555555);
    for (int i = 0; i < 15; i++) begin
      atom_valid = 1'b1;
      atom = TAKEN;
      if (i == 14) check("full_pre_valid", 32'(frame_valid), 32'd0);
      tick();
    end
    atom_valid = 1'b0;
    check("full_valid", 32'(frame_valid), 32'd1);
    check("full_count", 32'(frame_count), 32'd15);
    check("full_dct_count", 32'(dct_count), 32'd0);
    tick();

    // Partial flush of three atoms, then a flush with nothing buffered.
    atom_valid = 1'b1;
    atom = TAKEN;     tick();
    atom = NOT_TAKEN; tick();
    atom = SYNC;      tick();
    atom_valid = 1'b0;
    push_exp(4'd3, 30'h0000001B);
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush3_valid", 32'(frame_valid), 32'd1);
    check("flush3_dct_count", 32'(dct_count), 32'd0);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush0_no_frame", 32'(frame_valid), 32'd0);

    // Flush coincident with an accepted atom includes that atom.
    atom_valid = 1'b1;
    atom = TAKEN; tick();
    atom = TAKEN; tick();
    atom = NOT_TAKEN; flush = 1'b1;
    push_exp(4'd3, 30'h00000016);
    tick();
    atom_valid = 1'b0; flush = 1'b0;
    check("flushacc_count", 32'(frame_count), 32'd3);
    tick();

    // Downstream stalled: one frame held, a full buffer behind it, then drops.
    out_ready = 1'b0;
    atom_valid = 1'b1; atom = SYNC; flush = 1'b1;
    push_exp(4'd1, 30'h00000003);
    tick();
    flush = 1'b0;
    push_exp(4'd15, 30'h2AAAAAAA);
    for (int i = 0; i < 15; i++) begin
      atom = NOT_TAKEN;
      tick();
    end
    check("stall_dct_count", 32'(dct_count), 32'd15);
    check("stall_dct_buffer", 32'(dct_buffer), 32'h2AAAAAAA);
    check("stall_no_ovf", 32'(overflow), 32'd0);
    atom = TAKEN;
    tick();
    tick();
    atom_valid = 1'b0;
    check("stall_ovf", 32'(overflow), 32'd1);
    check("stall_keep_count", 32'(dct_count), 32'd15);
`ifdef NIOS_OCI_DCT_DROP_COUNT_EN
    check("drop_count2", 32'(drop_count), 32'd2);
`endif
    atom_valid = 1'b1; clear_overflow = 1'b1;
    tick();
    atom_valid = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
`ifdef NIOS_OCI_DCT_DROP_COUNT_EN
    check("drop_count_clr_drop", 32'(drop_count), 32'd1);
`endif
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
`ifdef NIOS_OCI_DCT_DROP_COUNT_EN
    check("drop_count_clr", 32'(drop_count), 32'd0);
`endif
    out_ready = 1'b1;
    tick();
    check("release_dct_count", 32'(dct_count), 32'd0);
    check("release_valid", 32'(frame_valid), 32'd1);
    check("release_count", 32'(frame_count), 32'd15);
    tick();

    // Buffer retained while tracing is disabled.
    atom_valid = 1'b1; atom = SYNC;
    repeat (7) tick();
    trace_enable = 1'b0;
    atom = TAKEN;
    for (int i = 0; i < 6; i++) begin
      atom_valid = (i % 2 == 0);
      tick();
    end
    atom_valid = 1'b0;
    check("dis_dct_buffer", 32'(dct_buffer), 32'h00003FFF);
    check("dis_dct_count", 32'(dct_count), 32'd7);

    // Asynchronous reset mid-frame, between clock edges.
    #2 reset_n = 1'b0;
    #1;
    check("arst_dct_count", 32'(dct_count), 32'd0);
    check("arst_dct_buffer", 32'(dct_buffer), 32'd0);
    check("arst_frame_data", 32'(frame_data), 32'd0);
    check("arst_frame_count", 32'(frame_count), 32'd0);
    check("arst_frame_valid", 32'(frame_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    trace_enable = 1'b1;
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    check("arst_no_frame", 32'(frame_valid), 32'd0);

    repeat (3) tick();
    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
